// File: rtl/wr_pack32_pkg.sv
// wr_pack32_pkg: shared states, half-select and byte-lane constants for the write packer
package wr_pack32_pkg;
  typedef enum logic {IDLE, HELD} state_t;
  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;
  localparam int BYTE_LO = 0;
  localparam int BYTE_HI = 1;
endpackage

// File: rtl/wr_pack32_byte_merge16.sv
// wr_pack32_byte_merge16: per-byte select between new write data and the register's current half
module wr_pack32_byte_merge16
  import wr_pack32_pkg::*;
(
  input  logic [15:0] din16,
  input  logic [1:0]  be16,
  input  logic [15:0] cur_half,
  output logic [15:0] merged
);
  assign merged = {be16[BYTE_HI] ? din16[15:8] : cur_half[15:8],
                   be16[BYTE_LO] ? din16[7:0]  : cur_half[7:0]};
endmodule

// File: rtl/wr_pack32.sv
// wr_pack32: packs half-word or word writes into one atomic 32-bit load for the downstream register
module wr_pack32
  import wr_pack32_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        wr16,
  input  logic        a1,
  input  logic [15:0] din16,
  input  logic [1:0]  be16,
  input  logic        wr32,
  input  logic [31:0] din32,
  input  logic [31:0] cur,
  output logic [31:0] d,
  output logic        ld,
  output logic        pend,
  output logic        tmo
);
  state_t state, state_n;
  logic [15:0] hold, hold_n, lo, hi;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [31:0] d_n;
  logic ld_n, tmo_n;
  wr_pack32_byte_merge16 u_lo (.din16(din16), .be16(be16), .cur_half(cur[15:0]),  .merged(lo));
  wr_pack32_byte_merge16 u_hi (.din16(din16), .be16(be16), .cur_half(cur[31:16]), .merged(hi));
  assign pend = (state == HELD);
  // wr32 outranks wr16; any write outranks the timeout
  always_comb begin
    state_n = state;
    hold_n  = hold;
    cnt_n   = cnt;
    d_n     = d;
    ld_n    = 1'b0;
    tmo_n   = 1'b0;
    if (wr32) begin
      d_n     = din32;
      ld_n    = 1'b1;
      state_n = IDLE;
    end else if (wr16 && a1 == HALF_LO) begin
      d_n     = {state == HELD ? hold : cur[31:16], lo};
      ld_n    = 1'b1;
      state_n = IDLE;
    end else if (wr16) begin
      hold_n  = hi;
      cnt_n   = '0;
      state_n = HELD;
    end else if (state == HELD) begin
      if (cnt == CNT_W'(TIMEOUT - 1)) begin
        tmo_n   = 1'b1;
        state_n = IDLE;
      end else begin
        cnt_n = cnt + 1'b1;
      end
    end
  end
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state <= IDLE;
      hold  <= '0;
      cnt   <= '0;
      d     <= '0;
      ld    <= 1'b0;
      tmo   <= 1'b0;
    end else begin
      state <= state_n;
      hold  <= hold_n;
      cnt   <= cnt_n;
      d     <= d_n;
      ld    <= ld_n;
      tmo   <= tmo_n;
    end
  end
endmodule

// File: tb/tb_wr_pack32.sv
// tb_wr_pack32: directed stimulus against a cycle-stamped behavioural model of the write packer
module tb_wr_pack32;
  localparam int TIMEOUT = 16;
  logic sys_clk = 1'b0, rst = 1'b1, wr16 = 1'b0, a1 = 1'b0, wr32 = 1'b0;
  logic [15:0] din16 = '0;
  logic [1:0] be16 = '0;
  logic [31:0] din32 = '0, cur = '0, d;
  logic ld, pend, tmo;
  int n_vec = 0, n_bad = 0;

  wr_pack32 #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .sys_clk(sys_clk), .rst(rst), .wr16(wr16), .a1(a1), .din16(din16), .be16(be16),
    .wr32(wr32), .din32(din32), .cur(cur), .d(d), .ld(ld), .pend(pend), .tmo(tmo)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] merge(input logic [15:0] dn, input logic [1:0] be,
                                        input logic [15:0] ch);
    logic [15:0] r;
    for (int b = 0; b < 2; b++) r[8*b +: 8] = be[b] ? dn[8*b +: 8] : ch[8*b +: 8];
    return r;
  endfunction

  // model: a held high half remembers the cycle it arrived and expires TIMEOUT cycles later
  initial begin
    int cyc, held_cyc;
    bit armed, m_held, m_ld, m_tmo;
    logic [15:0] m_hold;
    logic [31:0] m_d;
    cyc = 0; held_cyc = 0; armed = 0; m_held = 0; m_ld = 0; m_tmo = 0;
    m_hold = '0; m_d = '0;
    forever begin
      @(posedge sys_clk);
      cyc++;
      if (rst) begin
        armed = 1; m_held = 0; m_d = '0; m_ld = 0; m_tmo = 0;
      end else begin
        m_ld = 0; m_tmo = 0;
        if (wr32) begin
          m_d = din32; m_ld = 1; m_held = 0;
        end else if (wr16 && !a1) begin
          m_d = {m_held ? m_hold : cur[31:16], merge(din16, be16, cur[15:0])};
          m_ld = 1; m_held = 0;
        end else if (wr16) begin
          m_held = 1; m_hold = merge(din16, be16, cur[31:16]); held_cyc = cyc;
        end else if (m_held && cyc - held_cyc == TIMEOUT) begin
          m_tmo = 1; m_held = 0;
        end
      end
      #1;
      if (armed) begin
        chk("model_d", d, m_d);
        chk("model_ld", {31'b0, ld}, {31'b0, m_ld});
        chk("model_tmo", {31'b0, tmo}, {31'b0, m_tmo});
        chk("model_pend", {31'b0, pend}, {31'b0, m_held});
      end
    end
  end

  task automatic w16(input logic a, input logic [15:0] dn, input logic [1:0] be);
    wr16 = 1'b1; a1 = a; din16 = dn; be16 = be;
    @(negedge sys_clk);
    wr16 = 1'b0;
  endtask

  task automatic w32(input logic [31:0] dn, input logic also16);
    wr32 = 1'b1; din32 = dn; wr16 = also16; a1 = 1'b1; din16 = 16'h7777; be16 = 2'b11;
    @(negedge sys_clk);
    wr32 = 1'b0; wr16 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  initial begin
    idle(2);
    chk("rst_d", d, 32'h0);
    chk("rst_ld", {31'b0, ld}, 32'h0);
    chk("rst_pend", {31'b0, pend}, 32'h0);
    chk("rst_tmo", {31'b0, tmo}, 32'h0);
    rst = 1'b0;
    idle(1);
    cur = 32'h11223344;
    w16(1'b1, 16'hAABB, 2'b11);
    chk("split_pend", {31'b0, pend}, 32'h1);
    idle(1);
    chk("split_noload", {31'b0, ld}, 32'h0);
    w16(1'b0, 16'hCCDD, 2'b01);
    chk("split_d", d, 32'hAABB33DD);
    chk("split_ld", {31'b0, ld}, 32'h1);
    chk("split_pend_clr", {31'b0, pend}, 32'h0);
    idle(1);
    chk("split_ld_once", {31'b0, ld}, 32'h0);
    chk("split_d_hold", d, 32'hAABB33DD);
    cur = 32'hDEADBEEF;
    w16(1'b0, 16'h1234, 2'b10);
    chk("lo_only_d", d, 32'hDEAD12EF);
    chk("lo_only_ld", {31'b0, ld}, 32'h1);
    w32(32'h01020304, 1'b1);
    chk("both_d", d, 32'h01020304);
    chk("both_pend", {31'b0, pend}, 32'h0);
    idle(1);
    w16(1'b1, 16'h4242, 2'b11);
    idle(15);
    chk("tmo_early", {31'b0, tmo}, 32'h0);
    chk("tmo_pend", {31'b0, pend}, 32'h1);
    idle(1);
    chk("tmo_fire", {31'b0, tmo}, 32'h1);
    chk("tmo_noload", {31'b0, ld}, 32'h0);
    chk("tmo_pend_clr", {31'b0, pend}, 32'h0);
    idle(1);
    chk("tmo_pulse", {31'b0, tmo}, 32'h0);
    cur = 32'h0;
    w16(1'b1, 16'h9999, 2'b11);
    idle(15);
    w16(1'b0, 16'h7777, 2'b11);
    chk("edge_d", d, 32'h99997777);
    chk("edge_ld", {31'b0, ld}, 32'h1);
    chk("edge_notmo", {31'b0, tmo}, 32'h0);
    idle(2);
    w16(1'b1, 16'h5555, 2'b11);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("rst_held_pend", {31'b0, pend}, 32'h0);
    cur = 32'hFFFF0000;
    w16(1'b0, 16'h0001, 2'b11);
    chk("rst_held_d", d, 32'hFFFF0001);
    w32(32'hA, 1'b0);
    chk("b2b_a", d, 32'hA);
    w32(32'hB, 1'b0);
    chk("b2b_b", d, 32'hB);
    chk("b2b_ld", {31'b0, ld}, 32'h1);
    w32(32'hC, 1'b0);
    chk("b2b_c", d, 32'hC);
    cur = 32'hCAFEBABE;
    w16(1'b0, 16'hFFFF, 2'b00);
    chk("be0_d", d, 32'hCAFEBABE);
    w16(1'b1, 16'h1357, 2'b01);
    w32(32'h24682468, 1'b0);
    chk("held_wr32_d", d, 32'h24682468);
    idle(TIMEOUT + 2);
    chk("held_wr32_notmo", {31'b0, tmo}, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
